// File: rtl/key_repeat_pulser_if.sv
// -----------------------------------------------------------------------------
// key_repeat_pulser_if
//   Bundles the per-channel key signals of key_repeat_pulser.
//
//   Parameter:
//     NUM_CH        number of key channels
//
//   Signals (all NUM_CH wide, bit n = channel n):
//     in_signal     raw asynchronous key levels, 1 = pressed
//     repeat_en     per-channel auto-repeat enable
//     out_pulse     one-cycle action pulse (press or repeat)
//     held          debounced key level
//     release_pulse one-cycle release pulse (zero unless KEY_RELEASE_PULSE_EN)
//
//   Modports:
//     master        key decode / game side: drives levels, receives pulses
//     slave         the pulser itself
// -----------------------------------------------------------------------------
interface key_repeat_pulser_if #(
   parameter int NUM_CH = 5
);
   logic [NUM_CH-1:0] in_signal;
   logic [NUM_CH-1:0] repeat_en;
   logic [NUM_CH-1:0] out_pulse;
   logic [NUM_CH-1:0] held;
   logic [NUM_CH-1:0] release_pulse;

   modport master (
      output in_signal,
      output repeat_en,
      input  out_pulse,
      input  held,
      input  release_pulse
   );

   modport slave (
      input  in_signal,
      input  repeat_en,
      output out_pulse,
      output held,
      output release_pulse
   );
endinterface

// File: rtl/key_repeat_pulser.sv
// -----------------------------------------------------------------------------
// key_repeat_pulser
//   Turns raw asynchronous key levels into clean one-cycle action pulses for
//   the game logic. Every channel runs through a synchronizer chain, a
//   debounce filter and a press/hold/repeat FSM (delayed auto shift).
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset, clears all state
//     bus      key_repeat_pulser_if.slave (in_signal, repeat_en in;
//              out_pulse, held, release_pulse out)
//
//   Parameters:
//     NUM_CH           independent channels (>=1)
//     SYNC_STAGES      synchronizer depth (>=2)
//     DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>=1)
//     REPEAT_DELAY     cycles from press pulse to first repeat (>=2)
//     REPEAT_RATE      cycles between later repeats (>=1)
//
//   Build option:
//     KEY_RELEASE_PULSE_EN  when defined, release_pulse fires for one cycle
//                           as the FSM returns to IDLE on a key release;
//                           otherwise release_pulse is tied to 0.
// -----------------------------------------------------------------------------
module key_repeat_pulser #(
   parameter int NUM_CH          = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 10,
   parameter int REPEAT_RATE     = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   key_repeat_pulser_if.slave      bus
);

   localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RCNT_W = $clog2(RMAX + 1);

   localparam logic [DCNT_W-1:0] DEB_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic [NUM_CH-1:0] sync_p0 [SYNC_STAGES];
   logic [NUM_CH-1:0] sync;

   logic [NUM_CH-1:0] db_p1;
   logic [DCNT_W-1:0] dcnt_p1 [NUM_CH];

   state_t            state_p2 [NUM_CH];
   logic [RCNT_W-1:0] rcnt_p2  [NUM_CH];
   logic [NUM_CH-1:0] out_pulse_p2;

   // ---- Stage 0: synchronizer chain ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_p0[i] <= '0;
         end
      end else begin
         sync_p0[0] <= bus.in_signal;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p0[i] <= sync_p0[i-1];
         end
      end
   end

   assign sync = sync_p0[SYNC_STAGES-1];

   // ---- Stage 1: debounce filter ----
   // Any return of sync to the accepted level restarts the count, so a
   // glitch shorter than DEBOUNCE_CYCLES never reaches db.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_p1 <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            dcnt_p1[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (sync[ch] == db_p1[ch]) begin
               dcnt_p1[ch] <= '0;
            end else if (dcnt_p1[ch] == DEB_LAST) begin
               db_p1[ch]   <= sync[ch];
               dcnt_p1[ch] <= '0;
            end else begin
               dcnt_p1[ch] <= dcnt_p1[ch] + 1'b1;
            end
         end
      end
   end

   // ---- Stage 2: press / hold / repeat FSM ----
`ifdef KEY_RELEASE_PULSE_EN
   logic [NUM_CH-1:0] release_p2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pulse_p2 <= '0;
`ifdef KEY_RELEASE_PULSE_EN
         release_p2   <= '0;
`endif
         for (int ch = 0; ch < NUM_CH; ch++) begin
            state_p2[ch] <= IDLE;
            rcnt_p2[ch]  <= '0;
         end
      end else begin
         out_pulse_p2 <= '0;
`ifdef KEY_RELEASE_PULSE_EN
         release_p2   <= '0;
`endif
         for (int ch = 0; ch < NUM_CH; ch++) begin
            case (state_p2[ch])
               IDLE: begin
                  if (db_p1[ch]) begin
                     out_pulse_p2[ch] <= 1'b1;
                     rcnt_p2[ch]      <= '0;
                     state_p2[ch]     <= HOLD;
                  end
               end
               HOLD: begin
                  if (!db_p1[ch]) begin
                     state_p2[ch] <= IDLE;
`ifdef KEY_RELEASE_PULSE_EN
                     release_p2[ch] <= 1'b1;
`endif
                  end else if (!bus.repeat_en[ch]) begin
                     rcnt_p2[ch] <= '0;
                  end else if (rcnt_p2[ch] == DELAY_LAST) begin
                     out_pulse_p2[ch] <= 1'b1;
                     rcnt_p2[ch]      <= '0;
                     state_p2[ch]     <= REPEAT;
                  end else begin
                     rcnt_p2[ch] <= rcnt_p2[ch] + 1'b1;
                  end
               end
               REPEAT: begin
                  // Release is checked first so it suppresses a repeat due
                  // in the same cycle.
                  if (!db_p1[ch]) begin
                     state_p2[ch] <= IDLE;
`ifdef KEY_RELEASE_PULSE_EN
                     release_p2[ch] <= 1'b1;
`endif
                  end else if (!bus.repeat_en[ch]) begin
                     // Dropping back to HOLD makes the full delay apply
                     // again once repeat is re-enabled.
                     rcnt_p2[ch]  <= '0;
                     state_p2[ch] <= HOLD;
                  end else if (rcnt_p2[ch] == RATE_LAST) begin
                     out_pulse_p2[ch] <= 1'b1;
                     rcnt_p2[ch]      <= '0;
                  end else begin
                     rcnt_p2[ch] <= rcnt_p2[ch] + 1'b1;
                  end
               end
               default: begin
                  state_p2[ch] <= IDLE;
                  rcnt_p2[ch]  <= '0;
               end
            endcase
         end
      end
   end

   assign bus.out_pulse = out_pulse_p2;
   assign bus.held      = db_p1;

`ifdef KEY_RELEASE_PULSE_EN
   assign bus.release_pulse = release_p2;
`else
   assign bus.release_pulse = '0;
`endif

endmodule

// File: tb/tb_key_repeat_pulser.sv
// -----------------------------------------------------------------------------
// tb_key_repeat_pulser
//   Scoreboard bench for key_repeat_pulser (2 channels, sync 2, debounce 4,
//   delay 10, rate 3). Stimulus pushes the expected pulse cycle/value into
//   queues; a monitor on the falling edge pops and compares each time the
//   DUT shows a nonzero out_pulse or release_pulse.
// -----------------------------------------------------------------------------
module tb_key_repeat_pulser;

   localparam int NCH = 2;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_fail;

   typedef struct {
      int         cyc;
      logic [1:0] val;
   } exp_t;

   exp_t pq[$];
   exp_t rq[$];

   key_repeat_pulser_if #(.NUM_CH(NCH)) bus ();

   key_repeat_pulser #(
      .NUM_CH         (NCH),
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_RATE    (3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_p(input int t, input logic [1:0] v);
      exp_t e;
      e.cyc = t;
      e.val = v;
      pq.push_back(e);
   endfunction

   function automatic void push_r(input int t, input logic [1:0] v);
      exp_t e;
      e.cyc = t;
      e.val = v;
      rq.push_back(e);
   endfunction

   // Always returns to the point 1 time unit after a rising edge.
   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: each nonzero output must match the head of its queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_pulse != '0) begin
            if (pq.size() == 0) begin
               check("pulse_unexpected", int'(bus.out_pulse), 0);
            end else begin
               e = pq.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_value", int'(bus.out_pulse), int'(e.val));
            end
         end
         if (bus.release_pulse != '0) begin
            if (rq.size() == 0) begin
               check("release_unexpected", int'(bus.release_pulse), 0);
            end else begin
               e = rq.pop_front();
               check("release_cycle", cyc, e.cyc);
               check("release_value", int'(bus.release_pulse), int'(e.val));
            end
         end
      end
   end

   initial begin
      int c;
      int r;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.in_signal = '0;
      bus.repeat_en = '0;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_out_pulse", int'(bus.out_pulse), 0);
      check("rst_held", int'(bus.held), 0);
      check("rst_release", int'(bus.release_pulse), 0);
      wait_until(3);
      rst_n = 1'b1;
      wait_until(6);

      // A: press without repeat -> single pulse at edge 7, held from edge 6
      c = cyc;
      bus.repeat_en = 2'b00;
      bus.in_signal = 2'b01;
      push_p(c + 7, 2'b01);
      wait_until(c + 5);
      check("A_held_before", int'(bus.held), 0);
      wait_until(c + 6);
      check("A_held_rise", int'(bus.held), 1);
      wait_until(c + 30);
      check("A_pending", pq.size(), 0);
      c = cyc;
      bus.in_signal = 2'b00;
`ifdef KEY_RELEASE_PULSE_EN
      push_r(c + 7, 2'b01);
`endif
      wait_until(c + 6);
      check("A_held_fall", int'(bus.held), 0);
      wait_until(c + 12);

      // B: press with repeat; release lands on the cycle of the next repeat
      c = cyc;
      bus.repeat_en = 2'b01;
      bus.in_signal = 2'b01;
      push_p(c + 7,  2'b01);
      push_p(c + 17, 2'b01);
      push_p(c + 20, 2'b01);
      push_p(c + 23, 2'b01);
      push_p(c + 26, 2'b01);
      push_p(c + 29, 2'b01);
      wait_until(c + 25);
      bus.in_signal = 2'b00;
`ifdef KEY_RELEASE_PULSE_EN
      push_r(c + 32, 2'b01);
`endif
      wait_until(c + 31);
      check("B_held_fall", int'(bus.held), 0);
      wait_until(c + 45);
      check("B_pending", pq.size(), 0);

      // C: 3-cycle glitch is rejected, 4-cycle pulse is accepted
      c = cyc;
      bus.in_signal = 2'b01;
      wait_until(c + 3);
      bus.in_signal = 2'b00;
      for (int k = 0; k < 10; k++) begin
         wait_until(c + 4 + k);
         check("C_glitch_held", int'(bus.held), 0);
      end
      wait_until(c + 20);
      c = cyc;
      bus.in_signal = 2'b01;
      push_p(c + 7, 2'b01);
`ifdef KEY_RELEASE_PULSE_EN
      push_r(c + 11, 2'b01);
`endif
      wait_until(c + 4);
      bus.in_signal = 2'b00;
      wait_until(c + 6);
      check("C_held_rise", int'(bus.held), 1);
      wait_until(c + 20);
      check("C_pending", pq.size(), 0);

      // D: two channels together, only ch0 repeats
      c = cyc;
      bus.repeat_en = 2'b01;
      bus.in_signal = 2'b11;
      push_p(c + 7,  2'b11);
      push_p(c + 17, 2'b01);
      push_p(c + 20, 2'b01);
      push_p(c + 23, 2'b01);
      push_p(c + 26, 2'b01);
      wait_until(c + 6);
      check("D_held_both", int'(bus.held), 3);
      wait_until(c + 22);
      bus.in_signal = 2'b00;
`ifdef KEY_RELEASE_PULSE_EN
      push_r(c + 29, 2'b11);
`endif
      wait_until(c + 40);
      check("D_pending", pq.size(), 0);

      // E: async reset while a repeat pulse is on the output
      c = cyc;
      bus.repeat_en = 2'b01;
      bus.in_signal = 2'b01;
      push_p(c + 7,  2'b01);
      push_p(c + 17, 2'b01);
      push_p(c + 20, 2'b01);
      wait_until(c + 23);
      check("E_pulse_before_rst", int'(bus.out_pulse), 1);
      rst_n = 1'b0;
      #1;
      check("E_rst_out_pulse", int'(bus.out_pulse), 0);
      check("E_rst_held", int'(bus.held), 0);
      bus.repeat_en = 2'b00;
      wait_until(c + 26);
      rst_n = 1'b1;
      r = cyc;
      push_p(r + 7, 2'b01);
      wait_until(r + 5);
      check("E_held_before", int'(bus.held), 0);
      wait_until(r + 6);
      check("E_held_rise", int'(bus.held), 1);
      wait_until(r + 15);
      bus.in_signal = 2'b00;
`ifdef KEY_RELEASE_PULSE_EN
      push_r(r + 22, 2'b01);
`endif
      wait_until(r + 30);

      check("end_pulse_queue", pq.size(), 0);
      check("end_release_queue", rq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
